// File: rtl/frame_dma_sequencer_pkg.sv
// Shared constants and the sequencer state type for the frame DMA path.
package frame_dma_sequencer_pkg;

  // Button words copied into data memory every frame.
  localparam int KEY_NUM         = 4;
  // Base address of the button words in data memory.
  localparam int KEY_MEM         = 'h3F0;
  localparam int DATA_ADDR_WIDTH = 10;
  localparam int DATA_WIDTH      = 16;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    START,
    COPY,
    RELEASE
  } seq_state_t;

endpackage

// File: rtl/frame_dma_sequencer_wport_mux.sv
// 2:1 mux steering either the CPU or the button DMA onto the data memory write port.
module wport_mux #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              dma_sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_dout,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din
);

  // Select the write source; the unselected port is fully ignored, including its enable.
  always_comb begin
    if (dma_sel) begin
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_din  = dma_dout;
    end else begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_dout;
    end
  end

endmodule

// File: rtl/frame_dma_sequencer.sv
// Per-frame sequencer: halts the CPU, kicks the button DMA, owns the data memory
// write port for KEY_NUM cycles, then releases the CPU. Keeps frame/drop statistics.
module frame_dma_sequencer
  import frame_dma_sequencer_pkg::*;
#(
  parameter int KEY_NUM         = frame_dma_sequencer_pkg::KEY_NUM,
  parameter int DATA_ADDR_WIDTH = frame_dma_sequencer_pkg::DATA_ADDR_WIDTH,
  parameter int HALT_TIMEOUT    = 64,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vsync,
  output logic                       cpu_halt,
  input  logic                       cpu_halt_ack,
  output logic                       copy_start,
  input  logic                       cpu_we,
  input  logic [DATA_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]      cpu_dout,
  input  logic                       dma_we,
  input  logic [DATA_ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0]      dma_dout,
  output logic                       mem_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_din,
  output logic                       busy,
  output logic [CNT_WIDTH-1:0]       frame_count,
  output logic [CNT_WIDTH-1:0]       drop_count
);

  localparam int TW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam int CW = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(HALT_TIMEOUT - 1);
  localparam logic [CW-1:0] COPY_LOAD  = CW'(KEY_NUM - 1);

  seq_state_t    state;
  logic          pending;
  logic          pending_nxt;
  logic [TW-1:0] timer;
  logic [CW-1:0] copy_cnt;
  logic          timeout;
  logic          overflow;
  logic [1:0]    drop_inc;
  logic          dma_sel;

  // Saturating add of up to two drop events in one cycle.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                  input logic [1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(inc);
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  // Frame queue and drop accounting: one frame may wait, further vsyncs while busy are drops.
  always_comb begin
    timeout     = (state == HALT_WAIT) && !cpu_halt_ack && (timer == TIMER_LAST);
    overflow    = 1'b0;
    pending_nxt = pending;
    if (state == IDLE) begin
      // A vsync coinciding with a queued frame stays queued behind it.
      if (vsync || pending) pending_nxt = pending && vsync;
    end else if (vsync) begin
      if (pending) overflow = 1'b1;
      else         pending_nxt = 1'b1;
    end
    drop_inc = {1'b0, timeout} + {1'b0, overflow};
  end

  // Sequencer FSM with registered halt/start/busy outputs and the statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cpu_halt    <= 1'b0;
      copy_start  <= 1'b0;
      busy        <= 1'b0;
      pending     <= 1'b0;
      timer       <= '0;
      copy_cnt    <= '0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      copy_start <= 1'b0;
      pending    <= pending_nxt;
      drop_count <= sat_add(drop_count, drop_inc);
      case (state)
        IDLE: begin
          if (vsync || pending) begin
            state    <= HALT_WAIT;
            cpu_halt <= 1'b1;
            busy     <= 1'b1;
            timer    <= '0;
          end
        end
        HALT_WAIT: begin
          if (cpu_halt_ack) begin
            state      <= START;
            copy_start <= 1'b1;
          end else if (timeout) begin
            state    <= RELEASE;
            cpu_halt <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        START: begin
          state    <= COPY;
          copy_cnt <= COPY_LOAD;
        end
        COPY: begin
          if (copy_cnt == '0) begin
            state       <= RELEASE;
            cpu_halt    <= 1'b0;
            frame_count <= frame_count + CNT_WIDTH'(1);
          end else begin
            copy_cnt <= copy_cnt - CW'(1);
          end
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cpu_halt <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // DMA owns the port only in START/COPY; reset hands it straight back to the CPU.
  assign dma_sel = ((state == START) || (state == COPY)) && !reset;

  wport_mux #(
    .ADDR_W(DATA_ADDR_WIDTH),
    .DATA_W(DATA_WIDTH)
  ) u_wport_mux (
    .dma_sel  (dma_sel),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .dma_we   (dma_we),
    .dma_addr (dma_addr),
    .dma_dout (dma_dout),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din)
  );

endmodule

// File: tb/tb_frame_dma_sequencer.sv
// Directed bench for frame_dma_sequencer: vector table plus hand-written corner sequences.
module tb_frame_dma_sequencer;

  localparam int AW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b0;
  logic          cpu_halt_ack = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = 8'h11;
  logic [15:0]   cpu_dout = 16'hAAAA;
  logic          dma_we = 1'b0;
  logic [AW-1:0] dma_addr = 8'h22;
  logic [15:0]   dma_dout = 16'h5555;
  logic          cpu_halt, copy_start, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [CW-1:0] frame_count, drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_dma_sequencer #(
    .KEY_NUM(4), .DATA_ADDR_WIDTH(AW), .HALT_TIMEOUT(8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .cpu_halt(cpu_halt), .cpu_halt_ack(cpu_halt_ack), .copy_start(copy_start),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .dma_we(dma_we), .dma_addr(dma_addr), .dma_dout(dma_dout),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .frame_count(frame_count), .drop_count(drop_count)
  );

  typedef struct {
    logic vs, ack, cwe, dwe;
    logic halt, start, bsy, dma;
    int   fc, dc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic vs, ack, cwe, dwe, halt, start, bsy, dma,
                     input int fc, input int dc, input int n);
    for (int k = 0; k < n; k++) tbl.push_back('{vs, ack, cwe, dwe, halt, start, bsy, dma, fc, dc});
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int n;

    // Basic frame, ack tied high; stray dma_we outside the copy window.
    add(1,1,0,1, 1,0,1,0, 0,0, 1);
    add(0,1,0,1, 1,1,1,1, 0,0, 1);
    add(0,1,1,1, 1,0,1,1, 0,0, 4);
    add(0,1,1,1, 0,0,1,0, 1,0, 1);
    add(0,0,0,1, 0,0,0,0, 1,0, 1);
    // Delayed ack; CPU write during HALT_WAIT reaches memory.
    add(1,0,1,0, 1,0,1,0, 1,0, 1);
    add(0,0,1,0, 1,0,1,0, 1,0, 4);
    add(0,1,0,0, 1,1,1,1, 1,0, 1);
    add(0,1,0,1, 1,0,1,1, 1,0, 4);
    add(0,1,0,1, 0,0,1,0, 2,0, 1);
    add(0,0,0,0, 0,0,0,0, 2,0, 1);
    // Halt timeout with ack held low: 8 halt cycles, one drop.
    add(1,0,0,1, 1,0,1,0, 2,0, 1);
    add(0,0,0,1, 1,0,1,0, 2,0, 7);
    add(0,0,0,1, 0,0,1,0, 2,1, 1);
    add(0,0,0,1, 0,0,0,0, 2,1, 1);

    // Reset state, with a stray DMA write present.
    cpu_we = 1'b0; dma_we = 1'b1;
    tick(); tick();
    chk("rst_halt",  cpu_halt, 0);
    chk("rst_start", copy_start, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_fc",    frame_count, 0);
    chk("rst_dc",    drop_count, 0);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 8'h11);
    reset = 1'b0;
    tick();

    foreach (tbl[i]) begin
      vsync = tbl[i].vs; cpu_halt_ack = tbl[i].ack; cpu_we = tbl[i].cwe; dma_we = tbl[i].dwe;
      tick();
      chk($sformatf("v%0d_halt", i),  cpu_halt,   tbl[i].halt);
      chk($sformatf("v%0d_start", i), copy_start, tbl[i].start);
      chk($sformatf("v%0d_busy", i),  busy,       tbl[i].bsy);
      chk($sformatf("v%0d_we", i),    mem_we,     tbl[i].dma ? tbl[i].dwe : tbl[i].cwe);
      chk($sformatf("v%0d_addr", i),  mem_addr,   tbl[i].dma ? 8'h22 : 8'h11);
      chk($sformatf("v%0d_din", i),   mem_din,    tbl[i].dma ? 16'h5555 : 16'hAAAA);
      chk($sformatf("v%0d_fc", i),    frame_count, tbl[i].fc);
      chk($sformatf("v%0d_dc", i),    drop_count,  tbl[i].dc);
    end

    // Three vsyncs during COPY: one queued, two dropped; queued frame then runs.
    do_reset();
    cpu_halt_ack = 1'b1; cpu_we = 1'b0; dma_we = 1'b1;
    vsync = 1'b1; tick();
    vsync = 1'b0; tick(); tick();
    vsync = 1'b1; tick(); tick(); tick();
    vsync = 1'b0;
    chk("q_dc_mid", drop_count, 2);
    chk("q_halt_mid", cpu_halt, 1);
    pulses = 0;
    n = 0;
    while (n < 30 && !(frame_count == 2 && !busy)) begin
      tick();
      if (copy_start) pulses++;
      n++;
    end
    chk("q_done_in_budget", (n < 30), 1);
    chk("q_fc", frame_count, 2);
    chk("q_dc", drop_count, 2);
    chk("q_pulses", pulses, 1);
    chk("q_halt_end", cpu_halt, 0);

    // Reset mid-COPY with a frame queued: everything clears, DMA is cut off.
    do_reset();
    cpu_halt_ack = 1'b1;
    vsync = 1'b1; tick();
    vsync = 1'b0; tick(); tick();
    vsync = 1'b1; tick();
    vsync = 1'b0;
    chk("r_in_copy", mem_addr, 8'h22);
    reset = 1'b1; cpu_we = 1'b0; dma_we = 1'b1;
    tick();
    chk("r_halt",  cpu_halt, 0);
    chk("r_start", copy_start, 0);
    chk("r_busy",  busy, 0);
    chk("r_we",    mem_we, 0);
    chk("r_addr",  mem_addr, 8'h11);
    chk("r_din",   mem_din, 16'hAAAA);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("r_stray_we%0d", k), mem_we, 0);
      chk($sformatf("r_idle%0d", k), busy, 0);
    end

    // Continuous vsync with ack low: overflow drops, timeout+overflow counts +2, saturation.
    do_reset();
    cpu_halt_ack = 1'b0; vsync = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("s_halt_before_to", cpu_halt, 1);
    chk("s_dc_before_to", drop_count, 6);
    tick();
    chk("s_halt_after_to", cpu_halt, 0);
    chk("s_dc_plus2", drop_count, 8);
    for (int k = 0; k < 30; k++) tick();
    chk("s_dc_sat", drop_count, 15);
    tick();
    chk("s_dc_sat_hold", drop_count, 15);
    chk("s_fc", frame_count, 0);
    vsync = 1'b0;

    // Frame counter wrap with a 4-bit counter.
    do_reset();
    cpu_halt_ack = 1'b1;
    for (int f = 0; f < 16; f++) begin
      vsync = 1'b1; tick();
      vsync = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      chk($sformatf("w_fc%0d", f), frame_count, (f + 1) % 16);
    end
    chk("w_dc", drop_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_dma_sequencer.md
# frame_dma_sequencer

Per-frame memory-access sequencer for the data memory write port. On each frame-start pulse it halts the CPU, waits for the CPU to acknowledge, pulses `copy_start` to the button DMA controller, routes the DMA write stream onto the data memory port for exactly `KEY_NUM` write cycles, then releases the CPU. It sits between the CPU data port, the button DMA controller and the data memory write port, and is the only source of `copy_start`.

## Interface
- `KEY_NUM`, `` `KEY_NUM ``: number of button words written per frame (≥1).
- `DATA_ADDR_WIDTH`, `` `DATA_ADDR_WIDTH ``: data memory address width.
- `HALT_TIMEOUT`, 64: max cycles to wait for `cpu_halt_ack` before abandoning the frame (≥2).
- `CNT_WIDTH`, 16: width of `frame_count` and `drop_count`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `vsync`  in  1  single-cycle frame-start pulse.
- `cpu_halt`  out  1  request CPU to stall data memory accesses.
- `cpu_halt_ack`  in  1  CPU is stalled; level, valid while `cpu_halt`=1.
- `copy_start`  out  1  one-cycle start pulse to the button DMA.
- `cpu_we`, `cpu_addr`, `cpu_dout`  in  1/`DATA_ADDR_WIDTH`/16  CPU write port.
- `dma_we`, `dma_addr`, `dma_dout`  in  1/`DATA_ADDR_WIDTH`/16  button DMA write port.
- `mem_we`, `mem_addr`, `mem_din`  out  1/`DATA_ADDR_WIDTH`/16  data memory write port.
- `busy`  out  1  high in any state other than IDLE.
- `frame_count`  out  `CNT_WIDTH`  completed copies, wraps.
- `drop_count`  out  `CNT_WIDTH`  dropped frames, saturates at all-ones.

## Operation
- States: IDLE, HALT_WAIT, START, COPY, RELEASE.
- IDLE: if `vsync` or `pending` → HALT_WAIT, clear `pending`, clear timer.
- HALT_WAIT: `cpu_halt`=1; timer increments each cycle. `cpu_halt_ack`=1 → START. If timer reaches `HALT_TIMEOUT`-1 without ack → RELEASE, increment `drop_count`.
- START: `cpu_halt`=1, `copy_start`=1 for exactly this cycle, load copy counter with `KEY_NUM`-1 → COPY.
- COPY: `cpu_halt`=1; counter decrements each cycle. At 0 → RELEASE, increment `frame_count`.
- RELEASE: `cpu_halt`=0 for one cycle → IDLE. This guarantees at least one CPU cycle between frames.
- Port mux (combinational on registered state): START or COPY selects the DMA port. All other states select the CPU port. In HALT_WAIT the CPU port stays selected so an in-flight CPU write completes.
- `vsync` while `busy`: if `pending`=0, set `pending`. If `pending` is already 1, the frame is dropped and `drop_count` increments. Only one frame is queued.
- Simultaneous events:
  - `vsync` in the RELEASE cycle sets `pending`.
  - Timeout drop and `vsync` overflow in the same cycle count as +2, saturating.
- `dma_we` asserted outside START/COPY is ignored; it never reaches `mem_we`.

## Timing
- Reset values:
  - state IDLE.
  - `cpu_halt`, `copy_start`, `busy`, `pending` all 0.
  - Counters 0.
  - `mem_*` follow the CPU port.
- `vsync` sampled at edge t: HALT_WAIT and `cpu_halt`=1 from t+1.
- Ack sampled at edge k: `copy_start`=1 during cycle k+1. The DMA writes during cycles k+2 … k+1+`KEY_NUM`, all of which are routed to memory (COPY spans exactly `KEY_NUM` cycles).
- `cpu_halt` deasserts in the cycle after the last COPY cycle. Minimum halt length, with ack already high: `KEY_NUM`+2 cycles.
- `cpu_halt`, `copy_start` and `busy` are registered, decoded directly from state flops; there are no glitches.
- Reset mid-operation, in any state, returns to IDLE next cycle:
  - `cpu_halt` and `copy_start` drop.
  - `pending` is cleared.
  - The mux returns to the CPU port immediately.

## Structure
- Shared constants package holds:
  - the state enum (`seq_state_t`);
  - `KEY_NUM`, `KEY_MEM` and the widths, as in `constants.svh`.
- One sub-module is natural: `wport_mux`, the 3-signal 2:1 write-port mux selected by `dma_sel`.
- FSM, timer, copy counter and stat counters live in the top module.

## Test plan
- Basic frame, `KEY_NUM`=4, ack tied high: `vsync` at cycle 10 → `cpu_halt` 11–16, `copy_start` only at 12, `mem_we` from the DMA at 13–16, `frame_count`=1.
- Delayed ack: ack rises 5 cycles after `cpu_halt` → `copy_start` exactly 1 cycle after the ack is sampled. A CPU write during HALT_WAIT reaches memory.
- Timeout, `HALT_TIMEOUT`=8, ack held low → `cpu_halt` high 8 cycles, then low. No `copy_start`, `drop_count`=1, `frame_count`=0.
- Back-to-back `vsync` pulses during COPY, 3 of them → one queued frame runs after RELEASE, `frame_count`=2, `drop_count`=2.
- Reset asserted mid-COPY → next cycle `cpu_halt`=0, `busy`=0, `mem_*` equal `cpu_*`. A stray `dma_we` afterwards never appears on `mem_we`.
- Counter wrap: preload via 2^`CNT_WIDTH` frames (or force) → `frame_count` wraps to 0, and `drop_count` saturates at all-ones.
